// File: rtl/instr_mem_arbiter_pkg.sv
// Shared constants and helpers for the instruction-memory arbiter slice.
package instr_mem_arbiter_pkg;

  localparam int WORD_OFS = 2;

  // Width of a CPU index; a single-requester build still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_next(input int k, input int n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts at the
// internal pointer, which moves just past the winner whenever a grant is made.
module rr_arbiter
  import instr_mem_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] cand,
  output logic [N-1:0] gnt
);

  localparam int IW = idx_w(N);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_next_ptr;
  logic          w_found;
  int            w_best;
  int            w_best_d;
  int            w_dist;

  // Winner is the candidate with the smallest circular distance from r_ptr.
  always_comb begin
    w_found    = 1'b0;
    w_best     = 0;
    w_best_d   = N;
    w_dist     = 0;
    w_next_ptr = r_ptr;
    gnt        = '0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i >= int'(r_ptr)) ? i - int'(r_ptr) : i + N - int'(r_ptr);
      if (cand[i] && (w_dist < w_best_d)) begin
        w_best_d = w_dist;
        w_best   = i;
        w_found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      gnt[i] = w_found && (w_best == i);
    end
    if (w_found) begin
      w_next_ptr = IW'(rr_next(w_best, N));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/instr_mem_arbiter.sv
// Shared instruction-ROM responder: per-CPU one-word fetch buffers plus a
// round-robin arbitrated single memory port with a fixed one-cycle read latency.
module instr_mem_arbiter
  import instr_mem_arbiter_pkg::*;
#(
  parameter int nCPUs = 3,
  parameter int MemAw = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [nCPUs-1:0]       req,
  input  logic [nCPUs-1:0][31:0] addr,
  output logic [nCPUs-1:0]       gnt,
  output logic [nCPUs-1:0]       rsp_valid,
  output logic [nCPUs-1:0][31:0] rsp_data,
  output logic                   mem_re,
  output logic [MemAw-1:0]       mem_addr,
  input  logic [31:0]            mem_rdata
);

  logic [MemAw-1:0]       r_tag [nCPUs];
  logic [nCPUs-1:0][31:0] r_data;
  logic [nCPUs-1:0]       r_vld;
  logic [nCPUs-1:0]       r_pend;
  logic [nCPUs-1:0]       r_rsp_valid;
  logic [nCPUs-1:0][31:0] r_rsp_data;
  logic [MemAw-1:0]       r_ptag;

  logic [MemAw-1:0]       w_widx [nCPUs];
  logic [nCPUs-1:0]       w_hit;
  logic [nCPUs-1:0]       w_cand;
  logic                   w_unused_addr;

  // Byte offset and bits above the ROM depth are deliberately dropped.
  assign w_unused_addr = ^addr;

  // A CPU being answered this cycle is not eligible again until the next one.
  always_comb begin
    w_hit  = '0;
    w_cand = '0;
    for (int i = 0; i < nCPUs; i++) begin
      w_widx[i] = addr[i][MemAw+1:WORD_OFS];
      w_hit[i]  = req[i] & r_vld[i] & (r_tag[i] == w_widx[i]) & ~r_rsp_valid[i];
      w_cand[i] = ~rst & req[i] & ~w_hit[i] & ~r_rsp_valid[i] & ~r_pend[i];
    end
  end

  rr_arbiter #(.N(nCPUs)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .cand (w_cand),
    .gnt  (gnt)
  );

  always_comb begin
    mem_re   = |gnt;
    mem_addr = '0;
    for (int i = 0; i < nCPUs; i++) begin
      if (gnt[i]) mem_addr = w_widx[i];
    end
  end

  // Memory responses bypass straight from the ROM; hits come from r_rsp_data.
  always_comb begin
    rsp_valid = r_rsp_valid;
    for (int i = 0; i < nCPUs; i++) begin
      rsp_data[i] = r_pend[i] ? mem_rdata : r_rsp_data[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld       <= '0;
      r_pend      <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_data      <= '0;
      r_ptag      <= '0;
      for (int i = 0; i < nCPUs; i++) r_tag[i] <= '0;
    end else begin
      r_rsp_valid <= w_hit | gnt;
      r_pend      <= gnt;
      if (mem_re) r_ptag <= mem_addr;
      for (int i = 0; i < nCPUs; i++) begin
        r_rsp_data[i] <= w_hit[i] ? r_data[i] : 32'h0;
        if (r_pend[i]) begin
          r_tag[i]  <= r_ptag;
          r_data[i] <= mem_rdata;
          r_vld[i]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Bench for instr_mem_arbiter: directed scenarios with literal expectations,
// then random traffic, all checked each cycle against a fetch-level model.
module tb_instr_mem_arbiter;

  localparam int N     = 3;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0][31:0] addr;
  logic [N-1:0]      gnt;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0][31:0] rsp_data;
  logic              mem_re;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_rdata;
  logic [31:0]       rom [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  instr_mem_arbiter #(.nCPUs(N), .MemAw(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr      (addr),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // ROM with one-cycle latency; garbage when not read.
  always @(posedge clk) mem_rdata <= mem_re ? rom[mem_addr] : $urandom();

  // ---------------- reference model (per-CPU fetch state) ----------------
  bit          m_bvld [N];
  int          m_btag [N];
  logic [31:0] m_bdata [N];
  bit          m_rv [N];
  bit          m_mem [N];
  logic [31:0] m_rdata [N];
  int          m_ptag [N];
  int          m_ptr;

  bit          n_bvld [N];
  int          n_btag [N];
  logic [31:0] n_bdata [N];
  bit          n_rv [N];
  bit          n_mem [N];
  logic [31:0] n_rdata [N];
  int          n_ptag [N];
  int          n_ptr;

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    a[AW+1:2] = AW'($urandom_range(0, 7));
    return a;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_bvld[i] = 0; m_btag[i] = 0; m_bdata[i] = '0;
      m_rv[i] = 0; m_mem[i] = 0; m_rdata[i] = '0; m_ptag[i] = 0;
    end
    m_ptr = 0;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // At the falling edge: predict this cycle's outputs, compare, and work out next state.
  task automatic eval();
    bit               hit [N];
    int               k;
    logic [N-1:0]     e_gnt;
    logic [N-1:0]     e_rv;
    logic [N-1:0][31:0] e_rd;
    logic [AW-1:0]    e_ma;
    @(negedge clk);
    if (rst) model_reset();
    e_gnt = '0; e_rv = '0; e_rd = '0; e_ma = '0; k = -1;
    for (int i = 0; i < N; i++) begin
      e_rv[i] = m_rv[i];
      if (m_rv[i]) e_rd[i] = m_rdata[i];
      hit[i] = !rst && req[i] && m_bvld[i] && (m_btag[i] == widx(addr[i])) && !m_rv[i];
    end
    for (int j = 0; j < N; j++) begin
      int c;
      c = (m_ptr + j) % N;
      if (k < 0 && !rst && req[c] && !hit[c] && !m_rv[c]) k = c;
    end
    if (k >= 0) begin
      e_gnt[k] = 1'b1;
      e_ma = AW'(widx(addr[k]));
    end
    chk("gnt", gnt, e_gnt);
    chk("mem_re", mem_re, k >= 0);
    chk("mem_addr", mem_addr, e_ma);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_data", rsp_data, e_rd);
    for (int i = 0; i < N; i++) begin
      n_bvld[i] = m_bvld[i]; n_btag[i] = m_btag[i]; n_bdata[i] = m_bdata[i];
      if (m_rv[i] && m_mem[i]) begin
        n_bvld[i] = 1; n_btag[i] = m_ptag[i]; n_bdata[i] = m_rdata[i];
      end
      n_rv[i]    = hit[i] || (i == k);
      n_mem[i]   = (i == k);
      n_ptag[i]  = widx(addr[i]);
      n_rdata[i] = hit[i] ? m_bdata[i] : ((i == k) ? rom[widx(addr[i])] : 32'h0);
    end
    n_ptr = (k >= 0) ? (k + 1) % N : m_ptr;
  endtask

  task automatic tick();
    @(posedge clk);
    m_bvld = n_bvld; m_btag = n_btag; m_bdata = n_bdata;
    m_rv = n_rv; m_mem = n_mem; m_rdata = n_rdata; m_ptag = n_ptag;
    m_ptr = n_ptr;
    #1;
  endtask

  task automatic drop_answered();
    for (int i = 0; i < N; i++) if (m_rv[i]) req[i] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom();
    rom[4] = 32'hDEAD_BEEF;
    model_reset();
    rst = 1'b1; req = '1; addr = '0;

    eval();
    chk("reset_gnt", gnt, 3'b000);
    chk("reset_mem_re", mem_re, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 3'b000);
    chk("reset_rsp_data", rsp_data, 96'h0);
    tick(); eval(); tick();
    rst = 1'b0; req = '0;

    // first fetch of 0x10 misses, then hits in the buffer
    req = 3'b001; addr[0] = 32'h10; eval();
    chk("t1_gnt", gnt, 3'b001);
    chk("t1_mem_re", mem_re, 1'b1);
    chk("t1_mem_addr", mem_addr, 6'd4);
    tick(); req[0] = 1'b0; eval();
    chk("t1_rsp_valid", rsp_valid, 3'b001);
    chk("t1_rsp_data0", rsp_data[0], 32'hDEAD_BEEF);
    chk("t1_mem_re_off", mem_re, 1'b0);
    tick(); req[0] = 1'b1; eval();
    chk("t2_mem_re", mem_re, 1'b0);
    chk("t2_gnt", gnt, 3'b000);
    tick(); req[0] = 1'b0; eval();
    chk("t2_rsp_valid", rsp_valid, 3'b001);
    chk("t2_rsp_data0", rsp_data[0], 32'hDEAD_BEEF);

    // park the pointer back on CPU0
    tick(); rst = 1'b1; eval(); tick(); rst = 1'b0;

    // three simultaneous misses
    req = 3'b111; addr[0] = 32'h0; addr[1] = 32'h4; addr[2] = 32'h8;
    eval();
    chk("t3_gnt0", gnt, 3'b001);
    tick(); drop_answered(); eval();
    chk("t3_gnt1", gnt, 3'b010);
    chk("t3_rv0", rsp_valid, 3'b001);
    tick(); drop_answered(); eval();
    chk("t3_gnt2", gnt, 3'b100);
    chk("t3_rv1", rsp_valid, 3'b010);
    tick(); drop_answered(); eval();
    chk("t3_rv2", rsp_valid, 3'b100);
    chk("t3_idle", mem_re, 1'b0);
    tick(); req = 3'b111; addr[0] = 32'h30; addr[1] = 32'h34; addr[2] = 32'h38; eval();
    chk("t3_wrap_gnt", gnt, 3'b001);
    repeat (4) begin tick(); drop_answered(); eval(); end

    // address wrap and ignored byte offset
    tick(); req = 3'b100; addr[2] = 32'h0000_0104; eval();
    chk("t4_mem_addr_wrap", mem_addr, 6'd1);
    tick(); drop_answered(); eval();
    tick(); req[2] = 1'b1; addr[2] = 32'h13; eval();
    chk("t4_gnt", gnt, 3'b100);
    chk("t4_mem_addr_low", mem_addr, 6'd4);
    tick(); drop_answered(); eval();

    // reset mid-fetch discards the response and the buffers
    tick(); req = 3'b010; addr[1] = 32'h20; eval();
    tick(); drop_answered(); eval();
    tick(); req[1] = 1'b1; addr[1] = 32'h24; eval();
    chk("t5_gnt", gnt, 3'b010);
    tick(); rst = 1'b1; eval();
    chk("t5_rsp_valid", rsp_valid, 3'b000);
    chk("t5_rsp_data", rsp_data, 96'h0);
    chk("t5_gnt_in_rst", gnt, 3'b000);
    tick(); rst = 1'b0; addr[1] = 32'h20; eval();
    chk("t5_refetch_mem_re", mem_re, 1'b1);
    chk("t5_refetch_addr", mem_addr, 6'd8);
    tick(); drop_answered(); req[0] = 1'b1; addr[0] = 32'h10; eval();
    tick(); drop_answered(); eval();
    tick(); eval();

    // hit on CPU0 alongside a miss on CPU1
    tick(); req = 3'b011; addr[0] = 32'h10; addr[1] = 32'h40; eval();
    chk("t6_gnt", gnt, 3'b010);
    chk("t6_mem_addr", mem_addr, 6'd16);
    tick(); drop_answered(); eval();
    chk("t6_rsp_valid", rsp_valid, 3'b011);
    chk("t6_rsp_data0", rsp_data[0], 32'hDEAD_BEEF);
    chk("t6_rsp_data1", rsp_data[1], rom[16]);

    // random traffic with occasional asynchronous resets
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (m_rv[i]) begin
          case ($urandom_range(0, 2))
            0:       req[i] = 1'b0;
            1:       ;
            default: addr[i] = rand_addr();
          endcase
        end else if (!req[i] && $urandom_range(0, 1) == 0) begin
          req[i] = 1'b1;
          if ($urandom_range(0, 1) == 1) addr[i] = rand_addr();
        end
      end
      eval();
    end

    tick();
    req = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
